// File: rtl/osc_tick_sched_pkg.sv
// Shared types, default parameters and the round-robin pick for osc_tick_sched.
// The optional periodic reload is enabled with the macro OSC_TICK_SCHED_PERIODIC_EN.
package osc_tick_sched_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RES_CYC     = 2;
    localparam int MAX_REQ         = 8;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } grant_t;

    // First set bit of elig at or after ptr, wrapping modulo n.
    function automatic grant_t rr_grant(input logic [MAX_REQ-1:0] elig,
                                        input logic [2:0]         ptr,
                                        input int                 n);
        grant_t g;
        int     c;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= n) c = c - n;
            if (k < n && !g.valid && elig[3'(c)]) begin
                g.valid = 1'b1;
                g.idx   = 3'(c);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/osc_tick_sync.sv
// Synchroniser for the asynchronous timer output followed by a registered
// rising-edge pulse that is only produced while enabled.
module osc_tick_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    assign level = sync_q[STAGES-1];

    // prev_q follows the level even while disabled, so a level that is already
    // high when RUN begins never counts as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= STAGES'({sync_q, din});
            prev_q <= level;
            pulse  <= en & level & ~prev_q;
        end
    end

endmodule

// File: rtl/osc_tick_sched.sv
// Shares the oscillator timer tick among N_REQ one-shot down-counters and keeps
// the timer powered only while a channel needs it. Macro: OSC_TICK_SCHED_PERIODIC_EN.
module osc_tick_sched
    import osc_tick_sched_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RES_CYC     = DEF_RES_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tmr_in,
    output logic                   osc_dis,
    output logic                   tmr_res,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] load_val,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       busy,
    output logic [N_REQ-1:0]       done,
    output logic                   tick
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RES_W = (RES_CYC > 1) ? $clog2(RES_CYC + 1) : 1;

    state_t             state, state_nxt;
    logic [RES_W-1:0]   res_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [N_REQ-1:0]   armed, busy_q, ack_q, done_q, elig, need;
    logic [CNT_W-1:0]   cnt [N_REQ];
    logic [CNT_W-1:0]   val [N_REQ];
`ifdef OSC_TICK_SCHED_PERIODIC_EN
    logic [CNT_W-1:0]   cap [N_REQ];
`endif
    logic               run;
    logic               tick_raw;
    logic               tick_run;
    grant_t             grant;

    assign run      = (state == ST_RUN);
    assign tick_run = tick_raw & run;

    osc_tick_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .din   (tmr_in),
        .pulse (tick_raw)
    );

    // A zero-valued eligible request is served without waking the timer.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            val[i]  = load_val[i*CNT_W +: CNT_W];
            elig[i] = req[i] & ~busy_q[i] & armed[i];
            need[i] = busy_q[i] | (elig[i] & (val[i] != '0));
        end
    end

    assign grant = rr_grant(MAX_REQ'(elig), 3'(ptr), N_REQ);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_OFF;
            res_cnt <= '0;
        end else begin
            state   <= state_nxt;
            res_cnt <= (state == ST_START) ? res_cnt + 1'b1 : '0;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        osc_dis   = 1'b1;
        tmr_res   = 1'b1;
        case (state)
            ST_OFF: begin
                if (|need) state_nxt = ST_START;
            end
            ST_START: begin
                osc_dis = 1'b0;
                if (res_cnt == RES_W'(RES_CYC - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                osc_dis = 1'b0;
                tmr_res = 1'b0;
                if (!(|need)) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // NOTE: the counter array is small and must read zero after reset, so it is
    // reset like ordinary flops rather than left as an uninitialised memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            armed  <= '1;
            busy_q <= '0;
            ack_q  <= '0;
            done_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
`ifdef OSC_TICK_SCHED_PERIODIC_EN
                cap[i] <= '0;
`endif
            end
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            if (grant.valid)
                ptr <= (int'(grant.idx) == N_REQ - 1) ? '0 : PTR_W'(int'(grant.idx) + 1);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i]) armed[i] <= 1'b1;
                // A channel being loaded is idle, so it never decrements on the same tick.
                if (grant.valid && int'(grant.idx) == i) begin
                    armed[i]  <= 1'b0;
                    ack_q[i]  <= 1'b1;
                    cnt[i]    <= val[i];
                    busy_q[i] <= (val[i] != '0);
                    done_q[i] <= (val[i] == '0);
`ifdef OSC_TICK_SCHED_PERIODIC_EN
                    cap[i]    <= val[i];
`endif
                end else if (busy_q[i] && tick_run && cnt[i] != '0) begin
                    if (cnt[i] == CNT_W'(1)) begin
                        done_q[i] <= 1'b1;
`ifdef OSC_TICK_SCHED_PERIODIC_EN
                        if (req[i] && cap[i] != '0) begin
                            cnt[i] <= cap[i];
                        end else begin
                            cnt[i]    <= '0;
                            busy_q[i] <= 1'b0;
                        end
`else
                        cnt[i]    <= '0;
                        busy_q[i] <= 1'b0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tick = tick_run;

endmodule

// File: tb/tb_osc_tick_sched.sv
// Directed bench for osc_tick_sched: reset, idle, single channel, zero load,
// re-arm, reset mid-count, contention and pointer wrap.
module tb_osc_tick_sched;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   tmr_in;
    logic                   osc_dis;
    logic                   tmr_res;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] load_val;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       busy;
    logic [N_REQ-1:0]       done;
    logic                   tick;

    int checks = 0;
    int errors = 0;

    osc_tick_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .SYNC_STAGES(2), .RES_CYC(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .tmr_in   (tmr_in),
        .osc_dis  (osc_dis),
        .tmr_res  (tmr_res),
        .req      (req),
        .load_val (load_val),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tmr_in pulse; returns in the cycle where the resulting counter update is visible.
    task automatic do_tick(input logic exp_tick);
        tmr_in = 1'b1;
        cyc(2);
        check("tick_early", tick, 1'b0);
        cyc(1);
        check("tick", tick, exp_tick);
        tmr_in = 1'b0;
        cyc(1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_osc_dis"}, osc_dis, 1'b1);
        check({tag, "_tmr_res"}, tmr_res, 1'b1);
        check({tag, "_ack"},     ack,     4'b0000);
        check({tag, "_busy"},    busy,    4'b0000);
        check({tag, "_done"},    done,    4'b0000);
        check({tag, "_tick"},    tick,    1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        tmr_in   = 1'b0;
        req      = '0;
        load_val = '0;
        cyc(2);
        check_reset_state("rst");
        reset = 1'b0;

        // Idle: timer stays off and edges on tmr_in produce no tick.
        for (int i = 0; i < 20; i++) begin
            tmr_in = ((i / 2) % 2) == 1;
            cyc(1);
            check("idle_osc_dis", osc_dis, 1'b1);
            check("idle_tmr_res", tmr_res, 1'b1);
            check("idle_tick",    tick,    1'b0);
        end
        tmr_in = 1'b0;
        cyc(3);

        // Single channel 0, count 3.
        load_val = {8'd0, 8'd0, 8'd0, 8'd3};
        req      = 4'b0001;
        cyc(1);
        check("single_ack",      ack,     4'b0001);
        check("single_busy",     busy,    4'b0001);
        check("single_st0_dis",  osc_dis, 1'b0);
        check("single_st0_res",  tmr_res, 1'b1);
        req = 4'b0000;
        cyc(1);
        check("single_ack_once", ack,     4'b0000);
        check("single_st1_res",  tmr_res, 1'b1);
        cyc(1);
        check("single_run_res",  tmr_res, 1'b0);
        check("single_run_dis",  osc_dis, 1'b0);
        do_tick(1'b1);
        check("single_t1_busy",  busy,    4'b0001);
        check("single_t1_done",  done,    4'b0000);
        do_tick(1'b1);
        check("single_t2_done",  done,    4'b0000);
        do_tick(1'b1);
        check("single_t3_done",  done,    4'b0001);
        check("single_t3_busy",  busy,    4'b0000);
        check("single_t3_dis",   osc_dis, 1'b0);
        cyc(1);
        check("single_off_dis",  osc_dis, 1'b1);
        check("single_off_res",  tmr_res, 1'b1);
        check("single_off_done", done,    4'b0000);

        // Zero load on channel 2: immediate ack+done, timer never wakes.
        load_val = {8'd0, 8'd0, 8'd0, 8'd0};
        req      = 4'b0100;
        cyc(1);
        check("zero_ack",  ack,     4'b0100);
        check("zero_done", done,    4'b0100);
        check("zero_busy", busy,    4'b0000);
        check("zero_dis",  osc_dis, 1'b1);
        req = 4'b0000;
        cyc(1);
        check("zero_dis2",  osc_dis, 1'b1);
        check("zero_done2", done,    4'b0000);
        check("zero_ack2",  ack,     4'b0000);

`ifndef OSC_TICK_SCHED_PERIODIC_EN
        // Re-arm: holding req after expiry gives no second accept.
        load_val = {8'd0, 8'd0, 8'd1, 8'd0};
        req      = 4'b0010;
        cyc(1);
        check("rearm_ack1", ack, 4'b0010);
        cyc(2);
        check("rearm_run", tmr_res, 1'b0);
        do_tick(1'b1);
        check("rearm_done", done, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("rearm_no_ack", ack, 4'b0000);
        end
        check("rearm_off", osc_dis, 1'b1);
        req = 4'b0000;
        cyc(1);
        req = 4'b0010;
        cyc(1);
        check("rearm_ack2", ack, 4'b0010);
        req = 4'b0000;
`endif

        // Reset mid-count: channel 0 loaded with 4, reset at count 2.
        reset = 1'b1;
        cyc(1);
        reset    = 1'b0;
        load_val = {8'd0, 8'd0, 8'd0, 8'd4};
        req      = 4'b0001;
        cyc(1);
        check("midrst_ack", ack, 4'b0001);
        req = 4'b0000;
        cyc(2);
        do_tick(1'b1);
        do_tick(1'b1);
        check("midrst_busy", busy, 4'b0001);
        check("midrst_done", done, 4'b0000);
        reset = 1'b1;
        cyc(1);
        check_reset_state("midrst");
        reset = 1'b0;
        tmr_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) tmr_in = 1'b0;
            cyc(1);
            check("midrst_no_done", done, 4'b0000);
            check("midrst_no_tick", tick, 1'b0);
        end

        // Contention: four requests, pointer at 0 after reset.
        load_val = {8'd5, 8'd5, 8'd5, 8'd5};
        req      = 4'b1111;
        cyc(1);
        check("cont_ack0", ack, 4'b0001);
        cyc(1);
        check("cont_ack1", ack, 4'b0010);
        cyc(1);
        check("cont_ack2", ack, 4'b0100);
        cyc(1);
        check("cont_ack3", ack, 4'b1000);
        check("cont_busy", busy, 4'b1111);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) do_tick(1'b1);
        check("cont_busy4", busy, 4'b1111);
        check("cont_done4", done, 4'b0000);
        do_tick(1'b1);
        check("cont_done", done, 4'b1111);
        check("cont_idle", busy, 4'b0000);
        cyc(1);
        check("cont_off", osc_dis, 1'b1);

        // Pointer wrapped back to 0: channel 0 wins over channel 1.
        load_val = {8'd0, 8'd0, 8'd1, 8'd1};
        req      = 4'b0011;
        cyc(1);
        check("ptr_ack0", ack, 4'b0001);
        cyc(1);
        check("ptr_ack1", ack, 4'b0010);
        req = 4'b0000;
        cyc(1);
        do_tick(1'b1);
        check("ptr_done", done, 4'b0011);

`ifdef OSC_TICK_SCHED_PERIODIC_EN
        // Periodic: req held with value 2 gives done every 2 ticks.
        reset = 1'b1;
        cyc(1);
        reset    = 1'b0;
        load_val = {8'd0, 8'd0, 8'd0, 8'd2};
        req      = 4'b0001;
        cyc(1);
        check("per_ack", ack, 4'b0001);
        cyc(2);
        do_tick(1'b1);
        check("per_d1_none", done, 4'b0000);
        do_tick(1'b1);
        check("per_d1", done, 4'b0001);
        check("per_busy1", busy, 4'b0001);
        check("per_no_ack", ack, 4'b0000);
        do_tick(1'b1);
        check("per_d2_none", done, 4'b0000);
        do_tick(1'b1);
        check("per_d2", done, 4'b0001);
        req = 4'b0000;
        do_tick(1'b1);
        do_tick(1'b1);
        check("per_last", done, 4'b0001);
        check("per_idle", busy, 4'b0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
